// File: rtl/instr_cache_sa_datapath.sv
// ----------------------------------------------------------------------------
// instr_cache_sa_datapath
//
// L0 instruction cache. It is set-associative, refills on a miss, picks a
// victim per set by round-robin, and can be flushed as a whole. It sits
// between the core fetch port and the instruction memory.
//
// Address split, with W = $clog2(RAM_WIDTH/32):
//    word offset = addr[W+1:2]
//    set index   = addr[W+1+LOG2_NUM_SETS : W+2]
//    tag         = addr[31 : W+2+LOG2_NUM_SETS]
//
// Parameters
//    LOG2_NUM_SETS : log2 of the set count. 0 gives a fully associative cache.
//    NUM_WAYS      : ways per set. Allowed values are 1, 2 and 4.
//    RAM_WIDTH     : line width in bits. A multiple of 32, at least 64.
//    CORE_WIDTH    : width of the returned data. Either 32 or RAM_WIDTH.
//
// Ports
//    clk           : clock, rising edge
//    rst           : asynchronous reset, active-high
//    flush_i       : invalidate all lines (pulse)
//    core_req_i    : fetch request
//    core_addr_i   : fetch byte address
//    core_gnt_o    : request accepted this cycle
//    core_rvalid_o : fetch data valid (1-cycle pulse)
//    core_rdata_o  : fetch data
//    mem_req_o     : line refill request
//    mem_addr_o    : line-aligned refill address
//    mem_gnt_i     : memory accepted the refill request
//    mem_rvalid_i  : refill line valid
//    mem_rdata_i   : refill line data
//    busy_o        : the FSM is not in IDLE, or a flush is pending
//
// Optional feature, enabled by the macro ICACHE_PERF_CNT_EN
//    hit_cnt_o     : saturating count of LOOKUP hits
//    miss_cnt_o    : saturating count of LOOKUP misses
//    A flush does not clear these counters. Only rst clears them.
// ----------------------------------------------------------------------------
module instr_cache_sa_datapath #(
   parameter int LOG2_NUM_SETS = 2,
   parameter int NUM_WAYS      = 2,
   parameter int RAM_WIDTH     = 128,
   parameter int CORE_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  core_req_i,
   input  logic [31:0]           core_addr_i,
   output logic                  core_gnt_o,
   output logic                  core_rvalid_o,
   output logic [CORE_WIDTH-1:0] core_rdata_o,
   output logic                  mem_req_o,
   output logic [31:0]           mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [RAM_WIDTH-1:0]  mem_rdata_i,
   output logic                  busy_o
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]           hit_cnt_o,
   output logic [31:0]           miss_cnt_o
`endif
);

   localparam int WORDS    = RAM_WIDTH / 32;
   localparam int OFF_W    = $clog2(WORDS);
   localparam int LINE_LSB = OFF_W + 2;
   localparam int NUM_SETS = 1 << LOG2_NUM_SETS;
   localparam int SET_W    = (LOG2_NUM_SETS > 0) ? LOG2_NUM_SETS : 1;
   localparam int TAG_LSB  = LINE_LSB + LOG2_NUM_SETS;
   localparam int TAG_W    = 32 - TAG_LSB;
   localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_LOOKUP      = 2'd1,
      ST_REFILL_REQ  = 2'd2,
      ST_REFILL_WAIT = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [31:0]            r_addr;
   logic                   r_flush_pend;

   logic [RAM_WIDTH-1:0]   r_data   [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]       r_tag    [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0]    r_valid  [NUM_SETS];
   logic [WAY_W-1:0]       r_rr_ptr [NUM_SETS];

   logic [SET_W-1:0]       w_set;
   logic [TAG_W-1:0]       w_tag;
   logic [OFF_W-1:0]       w_off;
   logic                   w_hit;
   logic [WAY_W-1:0]       w_hit_way;
   logic [WAY_W-1:0]       w_victim;
   logic                   w_flush_any;
   logic                   w_lookup_hit;
   logic                   w_lookup_miss;
   logic                   w_gnt;
   logic                   w_refill_wr;
   logic                   w_resp;
   logic                   w_flush_apply;
   logic [RAM_WIDTH-1:0]   w_line;
   logic [CORE_WIDTH-1:0]  w_rdata;
   logic [31:0]            w_line_addr;
   logic                   w_unused_addr_bits;

   // The byte-within-word bits are carried in the address register but never read.
   assign w_unused_addr_bits = ^r_addr[1:0];

   // Field extraction from the registered fetch address.
   assign w_tag       = r_addr[31:TAG_LSB];
   assign w_off       = r_addr[LINE_LSB-1:2];
   assign w_line_addr = {r_addr[31:LINE_LSB], {LINE_LSB{1'b0}}};

   generate
      if (LOG2_NUM_SETS > 0) begin : g_set_idx
         assign w_set = r_addr[TAG_LSB-1:LINE_LSB];
      end else begin : g_set_fa
         assign w_set = {SET_W{1'b0}};
      end
   endgenerate

   // Tag compare across the ways. The loop runs from the top way down so the
   // lowest matching way wins.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = {WAY_W{1'b0}};
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         w_hit_way = (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) ? WAY_W'(w) : w_hit_way;
         w_hit     = w_hit | (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag));
      end
   end

   // Victim selection. The lowest invalid way is taken first. If every way is
   // valid, the way at the set's round-robin pointer is taken.
   always_comb begin
      w_victim = r_rr_ptr[w_set];
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         w_victim = (!r_valid[w_set][w]) ? WAY_W'(w) : w_victim;
      end
   end

   // A flush seen in this cycle blocks a grant in the same way as a latched flush.
   assign w_flush_any   = r_flush_pend | flush_i;
   assign w_lookup_hit  = (r_state == ST_LOOKUP) & w_hit;
   assign w_lookup_miss = (r_state == ST_LOOKUP) & ~w_hit;
   assign w_gnt         = core_req_i & ~w_flush_any & ((r_state == ST_IDLE) | w_lookup_hit);
   assign w_refill_wr   = (r_state == ST_REFILL_WAIT) & mem_rvalid_i;
   assign w_resp        = w_lookup_hit | w_refill_wr;
   // An IDLE flush clears the valid bits at once. Any other flush waits for the response cycle.
   assign w_flush_apply = ((r_state == ST_IDLE) & flush_i) | (w_resp & w_flush_any);

   // During a refill the line comes straight from memory, so the response is
   // given in the same cycle as mem_rvalid_i.
   assign w_line = (r_state == ST_REFILL_WAIT) ? mem_rdata_i : r_data[w_set][w_hit_way];

   generate
      if (CORE_WIDTH == 32) begin : g_word_sel
         assign w_rdata = w_line[32*w_off +: 32];
      end else begin : g_line_sel
         assign w_rdata = w_line;
      end
   endgenerate

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt) begin
               w_state_nxt = ST_LOOKUP;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            if (!w_hit) begin
               w_state_nxt = ST_REFILL_REQ;
            end else if (w_gnt) begin
               w_state_nxt = ST_LOOKUP;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REFILL_REQ: begin
            // A mem_rvalid_i that arrives together with mem_gnt_i is ignored here.
            if (mem_gnt_i) begin
               w_state_nxt = ST_REFILL_WAIT;
            end else begin
               w_state_nxt = ST_REFILL_REQ;
            end
         end
         ST_REFILL_WAIT: begin
            if (mem_rvalid_i) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_REFILL_WAIT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM output logic.
   always_comb begin
      core_gnt_o    = w_gnt;
      core_rvalid_o = 1'b0;
      mem_req_o     = 1'b0;
      mem_addr_o    = 32'h0000_0000;
      case (r_state)
         ST_IDLE: begin
            core_rvalid_o = 1'b0;
         end
         ST_LOOKUP: begin
            core_rvalid_o = w_hit;
         end
         ST_REFILL_REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = w_line_addr;
         end
         ST_REFILL_WAIT: begin
            core_rvalid_o = mem_rvalid_i;
         end
         default: begin
            core_rvalid_o = 1'b0;
         end
      endcase
      core_rdata_o = w_resp ? w_rdata : {CORE_WIDTH{1'b0}};
      busy_o       = (r_state != ST_IDLE) | r_flush_pend;
   end

   // Fetch address register. It loads only on a grant, so mem_addr_o stays stable through the refill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= 32'h0000_0000;
      end else if (w_gnt) begin
         r_addr <= core_addr_i;
      end else begin
         r_addr <= r_addr;
      end
   end

   // Flush-pending flag. It is set by a flush outside IDLE and cleared when the response is given.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush_pend <= 1'b0;
      end else if (w_resp) begin
         r_flush_pend <= 1'b0;
      end else if (flush_i && (r_state != ST_IDLE)) begin
         r_flush_pend <= 1'b1;
      end else begin
         r_flush_pend <= r_flush_pend;
      end
   end

   // Valid bits and round-robin pointers. A flush also invalidates a line being refilled in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            r_valid[s]  <= {NUM_WAYS{1'b0}};
            r_rr_ptr[s] <= {WAY_W{1'b0}};
         end
      end else begin
         if (w_refill_wr) begin
            r_valid[w_set][w_victim] <= 1'b1;
            if (r_rr_ptr[w_set] == WAY_W'(NUM_WAYS - 1)) begin
               r_rr_ptr[w_set] <= {WAY_W{1'b0}};
            end else begin
               r_rr_ptr[w_set] <= r_rr_ptr[w_set] + {{(WAY_W-1){1'b0}}, 1'b1};
            end
         end
         if (w_flush_apply) begin
            for (int s = 0; s < NUM_SETS; s++) begin
               r_valid[s] <= {NUM_WAYS{1'b0}};
            end
         end
      end
   end

   // Line data and tag storage. It has no reset because the valid bits decide whether an entry is used.
   always_ff @(posedge clk) begin
      if (w_refill_wr) begin
         r_data[w_set][w_victim] <= mem_rdata_i;
         r_tag[w_set][w_victim]  <= w_tag;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   // Saturating hit and miss counters for LOOKUP cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit_cnt  <= 32'h0000_0000;
         r_miss_cnt <= 32'h0000_0000;
      end else begin
         if (w_lookup_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_lookup_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = r_hit_cnt;
   assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_instr_cache_sa_datapath.sv
// Self-checking bench for instr_cache_sa_datapath (default parameters:
// 4 sets, 2 ways, 128-bit lines, 32-bit core data).
module tb_instr_cache_sa_datapath;

   localparam int RAM_WIDTH  = 128;
   localparam int CORE_WIDTH = 32;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  flush_i;
   logic                  core_req_i;
   logic [31:0]           core_addr_i;
   logic                  core_gnt_o;
   logic                  core_rvalid_o;
   logic [CORE_WIDTH-1:0] core_rdata_o;
   logic                  mem_req_o;
   logic [31:0]           mem_addr_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic [RAM_WIDTH-1:0]  mem_rdata_i;
   logic                  busy_o;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0]           hit_cnt_o;
   logic [31:0]           miss_cnt_o;
`endif

   instr_cache_sa_datapath #(
      .LOG2_NUM_SETS(2), .NUM_WAYS(2), .RAM_WIDTH(RAM_WIDTH), .CORE_WIDTH(CORE_WIDTH)
   ) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_gnt_o(core_gnt_o),
      .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
`ifdef ICACHE_PERF_CNT_EN
      , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [31:0] data; int gnt_cyc; bit is_hit; } sb_t;
   sb_t sb[$];

   typedef struct { logic [31:0] addr; bit hit; } vec_t;
   vec_t vecs[13];

   int          refill_cnt = 0;
   bit          mem_busy   = 1'b0;
   int          gnt_delay  = 1;
   int          rv_delay   = 2;
   bit          dual       = 1'b0;
   logic [31:0] exp_line   = 32'h0;
   int          exp_hits   = 0;
   int          exp_misses = 0;

   // Memory image: each word is a function of its own address.
   function automatic logic [127:0] line_data(input logic [31:0] la);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[32*i +: 32] = 32'hA500_0000 ^ (la + 32'(i));
      return l;
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] a);
      logic [127:0] l;
      l = line_data({a[31:4], 4'h0});
      return l[32*a[3:2] +: 32];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Response monitor: every core_rvalid_o is matched against the scoreboard.
   always @(negedge clk) begin
      if (!rst && core_rvalid_o) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_rvalid: got data %h, expected no response", core_rdata_o);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("rdata", core_rdata_o, e.data);
            if (e.is_hit) check("hit_latency", 32'(cyc), 32'(e.gnt_cyc + 1));
            else          check("bypass_same_cycle", {31'b0, mem_rvalid_i}, 32'd1);
         end
      end
   end

   // Memory responder. It checks the refill address, then grants, then returns the line.
   initial begin
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (!rst && mem_req_o) begin
            logic [31:0] la;
            mem_busy = 1'b1;
            refill_cnt++;
            la = mem_addr_o;
            check("mem_addr", la, exp_line);
            for (int i = 0; i < gnt_delay; i++) begin
               @(negedge clk);
               check("mem_req_hold", {31'b0, mem_req_o}, 32'd1);
               check("mem_addr_hold", mem_addr_o, la);
            end
            @(posedge clk); #1;
            mem_gnt_i = 1'b1; mem_rvalid_i = dual; mem_rdata_i = ~line_data(la);
            @(posedge clk); #1;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            repeat (rv_delay) @(posedge clk);
            #1;
            mem_rvalid_i = 1'b1; mem_rdata_i = line_data(la);
            @(posedge clk); #1;
            mem_rvalid_i = 1'b0; mem_rdata_i = '0;
            mem_busy = 1'b0;
         end
      end
   end

   task automatic fetch(input logic [31:0] a, input bit exp_hit, output int waits);
      bit   got;
      sb_t  e;
      got   = 1'b0;
      waits = 0;
      core_req_i  = 1'b1;
      core_addr_i = a;
      exp_line    = {a[31:4], 4'h0};
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (core_gnt_o) begin
            got = 1'b1;
            e.data = word_of(a); e.gnt_cyc = cyc; e.is_hit = exp_hit;
            sb.push_back(e);
         end else begin
            waits++;
         end
         @(posedge clk); #1;
      end
      core_req_i = 1'b0;
      if (!got) fail_now("gnt_timeout");
      if (exp_hit) exp_hits++; else exp_misses++;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (!busy_o && sb.size() == 0 && !mem_busy) ok = 1'b1;
      end
      if (!ok) fail_now("idle_timeout");
      @(posedge clk); #1;
   endtask

   task automatic wait_mem_gnt();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (mem_gnt_i) ok = 1'b1;
      end
      if (!ok) fail_now("mem_gnt_timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w;
      int r0;
      logic [31:0] b2b[6];

      rst = 1'b1; flush_i = 1'b0; core_req_i = 1'b0; core_addr_i = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt",    {31'b0, core_gnt_o},    32'd0);
      check("rst_rvalid", {31'b0, core_rvalid_o}, 32'd0);
      check("rst_rdata",  core_rdata_o,           32'd0);
      check("rst_memreq", {31'b0, mem_req_o},     32'd0);
      check("rst_memaddr", mem_addr_o,            32'd0);
      check("rst_busy",   {31'b0, busy_o},        32'd0);
`ifdef ICACHE_PERF_CNT_EN
      check("rst_hitcnt",  hit_cnt_o,  32'd0);
      check("rst_misscnt", miss_cnt_o, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      // Sets are addr[5:4]. A, B and C (0x100, 0x200, 0x300) share set 0.
      vecs[0]  = '{32'h0000_0100, 1'b0};  // cold miss A
      vecs[1]  = '{32'h0000_0104, 1'b1};
      vecs[2]  = '{32'h0000_010C, 1'b1};
      vecs[3]  = '{32'h0000_0110, 1'b0};  // set 1
      vecs[4]  = '{32'h0000_0118, 1'b1};
      vecs[5]  = '{32'h0000_0200, 1'b0};  // B goes to way 1
      vecs[6]  = '{32'h0000_0208, 1'b1};
      vecs[7]  = '{32'h0000_0300, 1'b0};  // C evicts A
      vecs[8]  = '{32'h0000_0204, 1'b1};  // B still resident
      vecs[9]  = '{32'h0000_0108, 1'b0};  // A misses and evicts B
      vecs[10] = '{32'h0000_030C, 1'b1};
      vecs[11] = '{32'h0000_0114, 1'b1};
      vecs[12] = '{32'h0000_0204, 1'b0};  // B misses and evicts C
      foreach (vecs[i]) begin
         r0 = refill_cnt;
         fetch(vecs[i].addr, vecs[i].hit, w);
         check("gnt_wait", 32'(w), 32'd0);
         wait_idle();
         check($sformatf("refills_v%0d", i), 32'(refill_cnt - r0), vecs[i].hit ? 32'd0 : 32'd1);
      end

      // Back-to-back hits: one grant per cycle with no bubble.
      b2b = '{32'h100, 32'h104, 32'h204, 32'h114, 32'h108, 32'h200};
      r0 = refill_cnt;
      foreach (b2b[i]) begin
         fetch(b2b[i], 1'b1, w);
         check("b2b_wait", 32'(w), 32'd0);
      end
      wait_idle();
      check("b2b_refills", 32'(refill_cnt - r0), 32'd0);

      // mem_gnt_i and a bogus mem_rvalid_i in the same cycle: the rvalid is ignored.
      dual = 1'b1;
      r0 = refill_cnt;
      fetch(32'h400, 1'b0, w);
      wait_idle();
      dual = 1'b0;
      check("dual_refills", 32'(refill_cnt - r0), 32'd1);

      // Flush during REFILL_WAIT: the response still arrives, and the grant stays low until it does.
      rv_delay = 4;
      r0 = refill_cnt;
      fetch(32'h500, 1'b0, w);
      wait_mem_gnt();
      @(posedge clk); #1; flush_i = 1'b1;
      @(posedge clk); #1; flush_i = 1'b0; core_req_i = 1'b1; core_addr_i = 32'h104;
      @(negedge clk);
      check("flush_pend_gnt",  {31'b0, core_gnt_o}, 32'd0);
      check("flush_pend_busy", {31'b0, busy_o},     32'd1);
      @(posedge clk); #1; core_req_i = 1'b0;
      wait_idle();
      rv_delay = 2;
      check("flush_refills", 32'(refill_cnt - r0), 32'd1);
      r0 = refill_cnt;
      fetch(32'h500, 1'b0, w);
      wait_idle();
      fetch(32'h104, 1'b0, w);
      wait_idle();
      check("after_flush_refills", 32'(refill_cnt - r0), 32'd2);

      // Flush together with a request in IDLE: the flush wins and no grant is given.
      @(negedge clk);
      @(posedge clk); #1; flush_i = 1'b1; core_req_i = 1'b1; core_addr_i = 32'h104;
      @(negedge clk);
      check("idle_flush_gnt", {31'b0, core_gnt_o}, 32'd0);
      @(posedge clk); #1; flush_i = 1'b0; core_req_i = 1'b0;
      r0 = refill_cnt;
      fetch(32'h104, 1'b0, w);
      wait_idle();
      check("idle_flush_refills", 32'(refill_cnt - r0), 32'd1);

      // Reset in the middle of a refill. The late memory response must be ignored.
      r0 = refill_cnt;
      fetch(32'h600, 1'b0, w);
      wait_mem_gnt();
      @(posedge clk); #1; rst = 1'b1;
      #1;
      check("midrst_busy",   {31'b0, busy_o},    32'd0);
      check("midrst_memreq", {31'b0, mem_req_o}, 32'd0);
      sb.delete();
      exp_hits = 0; exp_misses = 0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      for (int i = 0; i < 50 && mem_busy; i++) @(posedge clk);
      #1;
      check("midrst_mem_done", {31'b0, mem_busy}, 32'd0);
      fetch(32'h104, 1'b0, w);   // valid bits were cleared by the reset
      wait_idle();
      fetch(32'h108, 1'b1, w);
      fetch(32'h10C, 1'b1, w);
      fetch(32'h100, 1'b1, w);
      wait_idle();
      fetch(32'h204, 1'b0, w);
      wait_idle();
      check("midrst_refills", 32'(refill_cnt - r0), 32'd3);
`ifdef ICACHE_PERF_CNT_EN
      check("hit_cnt",  hit_cnt_o,  32'(exp_hits));
      check("miss_cnt", miss_cnt_o, 32'(exp_misses));
      @(posedge clk); #1; flush_i = 1'b1;
      @(posedge clk); #1; flush_i = 1'b0;
      @(negedge clk);
      check("hit_cnt_flush",  hit_cnt_o,  32'(exp_hits));
      check("miss_cnt_flush", miss_cnt_o, 32'(exp_misses));
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
